// File: rtl/fetchflare_pref_issue_queue_pkg.sv
// Shared widths, types and helpers for the prefetch issue queue.
// Captured addresses are stored line-aligned, so duplicate compares are plain equality.
package fetchflare_pref_pkg;
    localparam int NUM_STREAMS     = 4;
    localparam int ADDR_WIDTH      = 40;
    localparam int LINE_OFFSET     = 6;
    localparam int FIFO_DEPTH      = 4;
    localparam int MAX_OUTSTANDING = 8;

    localparam int STREAM_IDX_W = $clog2(NUM_STREAMS);
    localparam int OUTST_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);

    typedef logic [ADDR_WIDTH-1:0]   addr_t;
    typedef logic [STREAM_IDX_W-1:0] stream_idx_t;

    typedef struct packed {
        addr_t       addr;
        stream_idx_t stream;
    } entry_t;

    function automatic addr_t line_align(input addr_t a);
        return {a[ADDR_WIDTH-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
    endfunction
endpackage

// File: rtl/fetchflare_pref_issue_queue_if.sv
// Arbiter-side and memory-side handshake bundle of the prefetch issue queue.
// The queue itself connects through the slave modport.
interface fetchflare_pref_issue_queue_if;
    import fetchflare_pref_pkg::*;

    logic [NUM_STREAMS-1:0]            grant;
    logic                              any_grant;
    logic [NUM_STREAMS*ADDR_WIDTH-1:0] stream_addr;
    logic [NUM_STREAMS-1:0]            stream_ack;
    logic                              arb_enable;
    logic                              mem_req_valid;
    logic                              mem_req_ready;
    addr_t                             mem_req_addr;
    stream_idx_t                       mem_req_stream;
    logic                              mem_resp_valid;

    modport master (
        output grant, any_grant, stream_addr, mem_req_ready, mem_resp_valid,
        input  stream_ack, arb_enable, mem_req_valid, mem_req_addr, mem_req_stream
    );

    modport slave (
        input  grant, any_grant, stream_addr, mem_req_ready, mem_resp_valid,
        output stream_ack, arb_enable, mem_req_valid, mem_req_addr, mem_req_stream
    );
endinterface

// File: rtl/fetchflare_pref_fifo.sv
// Synchronous issue FIFO; exposes all slots plus an occupancy mask so the
// caller can compare a new line against everything still queued.
module fetchflare_pref_fifo
    import fetchflare_pref_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  entry_t                wr_entry,
    input  logic                  pop,
    output entry_t                rd_entry,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count,
    output entry_t                entries [FIFO_DEPTH],
    output logic [FIFO_DEPTH-1:0] entry_valid
);
    entry_t             mem_q [FIFO_DEPTH];
    entry_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rel_offs [FIFO_DEPTH];
    logic               do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign count    = count_q;
    assign rd_entry = mem_q[rd_ptr_q];
    assign entries  = mem_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            rel_offs[i]    = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, rel_offs[i]} < count_q);
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/fetchflare_pref_issue_queue.sv
// Prefetch issue queue: captures the granted stream's line, drops duplicates,
// buffers it and issues to memory while tracking credits against responses.
module fetchflare_pref_issue_queue
    import fetchflare_pref_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    fetchflare_pref_issue_queue_if.slave bus,
    output logic [OUTST_W-1:0]           outstanding,
    output logic [15:0]                  dup_count,
    output logic                         resp_underflow
);
    entry_t                fifo_head;
    entry_t                fifo_entries [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_valid;
    logic                  fifo_empty, fifo_full;
    logic [CNT_W-1:0]      fifo_count;

    logic [OUTST_W-1:0]    outstanding_q, outstanding_d;
    logic [15:0]           dup_count_q, dup_count_d;
    logic                  resp_underflow_q, resp_underflow_d;

    logic [OUTST_W:0]      credit_sum;
    logic                  accept, dup_hit, push, pop;
    addr_t                 cap_raw, cap_addr;
    stream_idx_t           cap_idx;
    entry_t                cap_entry;

    // Credits are judged on registered state only; a dequeue this cycle frees nothing yet.
    assign credit_sum     = (OUTST_W+1)'(fifo_count) + (OUTST_W+1)'(outstanding_q);
    assign bus.arb_enable = !fifo_full && (credit_sum < (OUTST_W+1)'(MAX_OUTSTANDING));
    assign accept         = bus.any_grant && bus.arb_enable;
    assign bus.stream_ack = bus.grant & {NUM_STREAMS{accept}};

    always_comb begin
        cap_raw = '0;
        cap_idx = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (bus.grant[i]) begin
                cap_raw = cap_raw | bus.stream_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                cap_idx = cap_idx | STREAM_IDX_W'(i);
            end
        end
        cap_addr = line_align(cap_raw);
        cap_entry.addr   = cap_addr;
        cap_entry.stream = cap_idx;
    end

    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_entries[i].addr == cap_addr)) begin
                dup_hit = 1'b1;
            end
        end
    end

    assign push = accept && !dup_hit;
    assign pop  = bus.mem_req_valid && bus.mem_req_ready;

    fetchflare_pref_fifo u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .wr_entry    (cap_entry),
        .pop         (pop),
        .rd_entry    (fifo_head),
        .empty       (fifo_empty),
        .full        (fifo_full),
        .count       (fifo_count),
        .entries     (fifo_entries),
        .entry_valid (fifo_valid)
    );

    assign bus.mem_req_valid  = !fifo_empty;
    assign bus.mem_req_addr   = fifo_head.addr;
    assign bus.mem_req_stream = fifo_head.stream;

    always_comb begin
        outstanding_d    = outstanding_q;
        resp_underflow_d = resp_underflow_q;
        dup_count_d      = dup_count_q;
        case ({pop, bus.mem_resp_valid})
            2'b10: outstanding_d = outstanding_q + 1'b1;
            2'b01: begin
                if (outstanding_q == '0) begin
                    resp_underflow_d = 1'b1;
                end else begin
                    outstanding_d = outstanding_q - 1'b1;
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
        if (accept && dup_hit && (dup_count_q != 16'hFFFF)) begin
            dup_count_d = dup_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_q    <= '0;
            dup_count_q      <= '0;
            resp_underflow_q <= 1'b0;
        end else begin
            outstanding_q    <= outstanding_d;
            dup_count_q      <= dup_count_d;
            resp_underflow_q <= resp_underflow_d;
        end
    end

    assign outstanding    = outstanding_q;
    assign dup_count      = dup_count_q;
    assign resp_underflow = resp_underflow_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
        bus.any_grant |-> $onehot(bus.grant));
endmodule

// File: tb/tb_fetchflare_pref_issue_queue.sv
// Bench for the prefetch issue queue: directed vector table, credit/reset
// sequences and random traffic checked against a queue-based model.
module tb_fetchflare_pref_issue_queue;
    import fetchflare_pref_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       outstanding;
    logic [15:0]      dup_count;
    logic             resp_underflow;

    int n_checks = 0;
    int n_errors = 0;

    fetchflare_pref_issue_queue_if bus ();

    fetchflare_pref_issue_queue dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.slave),
        .outstanding    (outstanding),
        .dup_count      (dup_count),
        .resp_underflow (resp_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] a;
        logic [1:0]  s;
    } ment_t;

    ment_t m_q[$];
    int    m_outst;
    int    m_dup;
    bit    m_uf;

    logic [3:0]  obs_ack;
    logic        obs_en, obs_vld, obs_uf;
    logic [39:0] obs_addr;
    logic [1:0]  obs_str;
    logic [3:0]  obs_outst;
    logic [15:0] obs_dup;

    typedef struct {
        logic [3:0]  g;
        logic        ag;
        logic [39:0] a;
        logic        rdy;
        logic        rsp;
        logic [3:0]  ack;
        logic        en;
        logic        vld;
        logic [39:0] ma;
        logic [1:0]  ms;
        logic [3:0]  os;
        logic [15:0] dp;
        logic        uf;
    } vec_t;

    vec_t tbl[$];

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic [3:0] g, logic ag, logic [39:0] a, logic rdy, logic rsp,
                                logic [3:0] ack, logic en, logic vld, logic [39:0] ma,
                                logic [1:0] ms, logic [3:0] os, logic [15:0] dp, logic uf);
        vec_t v;
        v.g = g; v.ag = ag; v.a = a; v.rdy = rdy; v.rsp = rsp;
        v.ack = ack; v.en = en; v.vld = vld; v.ma = ma; v.ms = ms;
        v.os = os; v.dp = dp; v.uf = uf;
        return v;
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_outst = 0;
        m_dup   = 0;
        m_uf    = 0;
    endfunction

    // One clock: drive, check at the falling edge against the model, then advance the model.
    task automatic step(input logic [3:0] g, input logic ag, input logic [159:0] sa,
                        input logic rdy, input logic rsp);
        int          occ;
        bit          en, acc, dup, pop;
        logic [39:0] line;
        logic [1:0]  idx;
        ment_t       e;
        bus.grant          = g;
        bus.any_grant      = ag;
        bus.stream_addr    = sa;
        bus.mem_req_ready  = rdy;
        bus.mem_resp_valid = rsp;
        @(negedge clk);
        occ = m_q.size();
        en  = (occ < 4) && (occ + m_outst < 8);
        acc = ag && en;
        check("ack", {60'd0, bus.stream_ack}, acc ? {60'd0, g} : 64'd0);
        check("arb_enable", {63'd0, bus.arb_enable}, {63'd0, en});
        check("mem_req_valid", {63'd0, bus.mem_req_valid}, {63'd0, occ > 0});
        if (occ > 0) begin
            check("mem_req_addr", {24'd0, bus.mem_req_addr}, {24'd0, m_q[0].a});
            check("mem_req_stream", {62'd0, bus.mem_req_stream}, {62'd0, m_q[0].s});
        end
        check("outstanding", {60'd0, outstanding}, 64'(m_outst));
        check("dup_count", {48'd0, dup_count}, 64'(m_dup));
        check("resp_underflow", {63'd0, resp_underflow}, {63'd0, m_uf});
        obs_ack = bus.stream_ack; obs_en = bus.arb_enable; obs_vld = bus.mem_req_valid;
        obs_addr = bus.mem_req_addr; obs_str = bus.mem_req_stream;
        obs_outst = outstanding; obs_dup = dup_count; obs_uf = resp_underflow;

        idx = 0;
        for (int i = 0; i < 4; i++) if (g[i]) idx = 2'(i);
        line = sa[idx*40 +: 40];
        line[5:0] = 6'd0;
        dup = 0;
        foreach (m_q[j]) if (m_q[j].a == line) dup = 1;
        pop = (occ > 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (acc && !dup) begin
            e.a = line; e.s = idx;
            m_q.push_back(e);
        end else if (acc && m_dup < 16'hFFFF) begin
            m_dup++;
        end
        if (pop && !rsp) m_outst++;
        else if (rsp && !pop) begin
            if (m_outst == 0) m_uf = 1;
            else m_outst--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.any_grant      = 1'b0;
        bus.grant          = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        check("rst_valid", {63'd0, bus.mem_req_valid}, 64'd0);
        check("rst_outst", {60'd0, outstanding}, 64'd0);
        check("rst_enable", {63'd0, bus.arb_enable}, 64'd1);
        check("rst_dup", {48'd0, dup_count}, 64'd0);
        check("rst_uf", {63'd0, resp_underflow}, 64'd0);
        check("rst_ack", {60'd0, bus.stream_ack}, 64'd0);
    endtask

    function automatic logic [159:0] place(logic [3:0] g, logic [39:0] a);
        logic [159:0] sa;
        sa = '0;
        for (int i = 0; i < 4; i++) if (g[i]) sa[i*40 +: 40] = a;
        return sa;
    endfunction

    initial begin
        reset              = 1'b1;
        bus.grant          = '0;
        bus.any_grant      = 1'b0;
        bus.stream_addr    = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Directed table: handshake latency, fill/backpressure, duplicate drop, underflow.
        tbl.push_back(mk(4'b0100, 1, 40'h10000047, 1, 0, 4'b0100, 1, 0, 40'h0, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 40'h0, 1, 0, 4'b0000, 1, 1, 40'h10000040, 2, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 40'h0, 0, 0, 4'b0000, 1, 0, 40'h0, 0, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 1, 40'h30000000, 0, 0, 4'b0001, 1, 0, 40'h0, 0, 1, 0, 0));
        tbl.push_back(mk(4'b0010, 1, 40'h30000040, 0, 0, 4'b0010, 1, 1, 40'h30000000, 0, 1, 0, 0));
        tbl.push_back(mk(4'b0100, 1, 40'h30000080, 0, 0, 4'b0100, 1, 1, 40'h30000000, 0, 1, 0, 0));
        tbl.push_back(mk(4'b1000, 1, 40'h300000C0, 0, 0, 4'b1000, 1, 1, 40'h30000000, 0, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 1, 40'h30000100, 0, 0, 4'b0000, 0, 1, 40'h30000000, 0, 1, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 40'h0, 1, 0, 4'b0000, 0, 1, 40'h30000000, 0, 1, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 40'h0, 1, 0, 4'b0000, 1, 1, 40'h30000040, 1, 2, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 40'h0, 1, 0, 4'b0000, 1, 1, 40'h30000080, 2, 3, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 40'h0, 1, 0, 4'b0000, 1, 1, 40'h300000C0, 3, 4, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 40'h0, 0, 0, 4'b0000, 1, 0, 40'h0, 0, 5, 0, 0));
        tbl.push_back(mk(4'b0001, 1, 40'h20000000, 0, 0, 4'b0001, 1, 0, 40'h0, 0, 5, 0, 0));
        tbl.push_back(mk(4'b0010, 1, 40'h2000003F, 0, 0, 4'b0010, 1, 1, 40'h20000000, 0, 5, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 40'h0, 0, 0, 4'b0000, 1, 1, 40'h20000000, 0, 5, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 40'h0, 1, 1, 4'b0000, 1, 1, 40'h20000000, 0, 5, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 40'h0, 0, 0, 4'b0000, 1, 0, 40'h0, 0, 5, 1, 0));
        for (int k = 5; k >= 1; k--)
            tbl.push_back(mk(4'b0000, 0, 40'h0, 0, 1, 4'b0000, 1, 0, 40'h0, 0, 4'(k), 1, 0));
        tbl.push_back(mk(4'b0000, 0, 40'h0, 0, 1, 4'b0000, 1, 0, 40'h0, 0, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 40'h0, 0, 0, 4'b0000, 1, 0, 40'h0, 0, 0, 1, 1));

        foreach (tbl[n]) begin
            step(tbl[n].g, tbl[n].ag, place(tbl[n].g, tbl[n].a), tbl[n].rdy, tbl[n].rsp);
            check($sformatf("tbl%0d_ack", n), {60'd0, obs_ack}, {60'd0, tbl[n].ack});
            check($sformatf("tbl%0d_en", n), {63'd0, obs_en}, {63'd0, tbl[n].en});
            check($sformatf("tbl%0d_vld", n), {63'd0, obs_vld}, {63'd0, tbl[n].vld});
            if (tbl[n].vld) begin
                check($sformatf("tbl%0d_addr", n), {24'd0, obs_addr}, {24'd0, tbl[n].ma});
                check($sformatf("tbl%0d_str", n), {62'd0, obs_str}, {62'd0, tbl[n].ms});
            end
            check($sformatf("tbl%0d_outst", n), {60'd0, obs_outst}, {60'd0, tbl[n].os});
            check($sformatf("tbl%0d_dup", n), {48'd0, obs_dup}, {48'd0, tbl[n].dp});
            check($sformatf("tbl%0d_uf", n), {63'd0, obs_uf}, {63'd0, tbl[n].uf});
        end

        // Credit limit: eight issues with no responses closes the window.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            logic [3:0] g;
            g = 4'b0001 << (k % 4);
            step(g, 1, place(g, 40'h50000000 + 40'(k) * 40'h40), 1, 0);
        end
        step(4'b0000, 0, '0, 1, 0);
        step(4'b0000, 0, '0, 1, 0);
        check("credit_full_en", {63'd0, obs_en}, 64'd0);
        check("credit_full_outst", {60'd0, obs_outst}, 64'd8);
        step(4'b0001, 1, place(4'b0001, 40'h60000000), 0, 1);
        check("credit_blocked_ack", {60'd0, obs_ack}, 64'd0);
        step(4'b0001, 1, place(4'b0001, 40'h60000000), 0, 0);
        check("credit_reopen_en", {63'd0, obs_en}, 64'd1);
        check("credit_reopen_ack", {60'd0, obs_ack}, 64'd1);
        step(4'b0000, 0, '0, 1, 1);
        check("credit_simul_before", {60'd0, obs_outst}, 64'd7);
        step(4'b0000, 0, '0, 0, 0);
        check("credit_simul_after", {60'd0, obs_outst}, 64'd7);

        // Reset with three entries queued and two in flight.
        do_reset();
        step(4'b0001, 1, place(4'b0001, 40'h70000000), 0, 0);
        step(4'b0010, 1, place(4'b0010, 40'h70000040), 1, 0);
        step(4'b0100, 1, place(4'b0100, 40'h70000080), 1, 0);
        step(4'b1000, 1, place(4'b1000, 40'h700000C0), 0, 0);
        step(4'b0001, 1, place(4'b0001, 40'h70000100), 0, 0);
        check("pre_rst_outst", {60'd0, outstanding}, 64'd2);
        check("pre_rst_valid", {63'd0, bus.mem_req_valid}, 64'd1);
        do_reset();
        step(4'b0000, 0, '0, 0, 0);

        // Random traffic against the model; a small line pool provokes duplicates.
        for (int k = 0; k < 2000; k++) begin
            logic [159:0] sa;
            logic [3:0]   g;
            for (int i = 0; i < 4; i++)
                sa[i*40 +: 40] = 40'h40000000 + 40'($urandom_range(0, 11)) * 40'h40
                                 + 40'($urandom_range(0, 63));
            g = 4'b0001 << $urandom_range(0, 3);
            step(g, ($urandom_range(0, 9) < 7), sa, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 3);
            if (k == 1000) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
